// File: rtl/cpu_fifo_periph.sv
// cpu_fifo_periph: CPU-mapped FIFO peripheral with a valid/ready drain port.
//
// The CPU pushes entries through the DATA register. It can read status,
// occupancy, control and threshold registers. A downstream consumer drains
// the FIFO head over out_data/out_valid/out_ready.
//
// Register map (Addr):
//   0 DATA   W: push DataIn           R: 0, no pop
//   1 STATUS R: {rd_err, overflow, full, empty}; W1C on bits 2 and 3
//   2 COUNT  R: occupancy
//   3 CTRL   W: bit0 flush (self-clearing), bit1 irq_en   R: {irq_en, 0}
//   4 THRESH R/W low-watermark threshold
//   A read of any other offset returns 0 and sets rd_err.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   CS, Rd_Wr, Addr        CPU access strobe, 1=read/0=write, register offset
//   DataIn                 CPU write data
//   DataOut, RdValid       read data, valid for one cycle two edges after the access
//   out_data, out_valid    FIFO head, FIFO not empty
//   out_ready              consumer accepts the head
//   irq                    low-watermark interrupt
//
// Optional feature macro: CPU_FIFO_IRQ_EN
//   Defined:   irq = irq_en && (count <= THRESH), registered.
//   Undefined: irq is tied low and irq_en is held at 0.
module cpu_fifo_periph #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CS,
    input  logic              Rd_Wr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              RdValid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              irq
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned CMP_W = (DATA_W > CNT_W) ? DATA_W : CNT_W;

    localparam logic [ADDR_W-1:0] A_DATA   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_THRESH = ADDR_W'(4);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              ovf, rd_err, irq_en;
    logic [DATA_W-1:0] thresh;
    logic [DATA_W-1:0] rd_data_q, rd_mux;
    logic              rd_pend;

    logic wr_acc, rd_acc, data_wr, status_wr, ctrl_wr, thresh_wr;
    logic flush, pop, pop_eff, push_ok, ovf_evt, rd_bad, full, empty;

    // Access decode and FIFO handshake qualification
    always_comb begin
        wr_acc    = CS && !Rd_Wr;
        rd_acc    = CS && Rd_Wr;
        data_wr   = wr_acc && (Addr == A_DATA);
        status_wr = wr_acc && (Addr == A_STATUS);
        ctrl_wr   = wr_acc && (Addr == A_CTRL);
        thresh_wr = wr_acc && (Addr == A_THRESH);
        flush     = ctrl_wr && DataIn[0];
        full      = (count == CNT_W'(DEPTH));
        empty     = (count == '0);
        pop       = out_valid && out_ready;
        // A flush discards the queue, so a same-edge pop must not move rd_ptr
        pop_eff   = pop && !flush;
        // When full, a push is only accepted if the head leaves on the same edge
        push_ok   = data_wr && (!full || pop);
        ovf_evt   = data_wr && !push_ok;
        rd_bad    = rd_acc && (Addr > A_THRESH);
    end

    // Next pointers and occupancy
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_nxt = wr_ptr + PTR_W'(1);
            end
            if (pop_eff) begin
                rd_ptr_nxt = rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_eff) begin
                count_nxt = count + CNT_W'(1);
            end else if (!push_ok && pop_eff) begin
                count_nxt = count - CNT_W'(1);
            end
        end
    end

    // Read mux built from pre-edge register state
    always_comb begin
        rd_mux = '0;
        case (Addr)
            A_STATUS: rd_mux = DATA_W'({rd_err, ovf, full, empty});
            A_COUNT:  rd_mux = DATA_W'(count);
            A_CTRL:   rd_mux = DATA_W'({irq_en, 1'b0});
            A_THRESH: rd_mux = thresh;
            default:  rd_mux = '0;
        endcase
    end

    // FIFO storage; contents are not reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= DataIn;
        end
    end

    assign out_data = mem[rd_ptr];

    // Pointers, occupancy, sticky flags and threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            rd_err    <= 1'b0;
            thresh    <= '0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            // Set events take priority over write-1-to-clear
            ovf       <= ovf_evt || (ovf && !(status_wr && DataIn[2]));
            rd_err    <= rd_bad || (rd_err && !(status_wr && DataIn[3]));
            if (thresh_wr) begin
                thresh <= DataIn;
            end
        end
    end

    // Two-stage read pipeline: capture at the access edge, present on the next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend   <= 1'b0;
            rd_data_q <= '0;
            RdValid   <= 1'b0;
            DataOut   <= '0;
        end else begin
            rd_pend <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= rd_mux;
            end
            RdValid <= rd_pend;
            if (rd_pend) begin
                DataOut <= rd_data_q;
            end
        end
    end

`ifdef CPU_FIFO_IRQ_EN
    // Interrupt enable and registered low-watermark interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en <= DataIn[1];
            end
            irq <= irq_en && (CMP_W'(count) <= CMP_W'(thresh));
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

endmodule
